// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared widths, address range and reader state encoding
package ram_pkg;

    localparam int ADDR_W   = 14;
    localparam int DATA_W   = 64;
    localparam int SAMPLE_W = 16;
    localparam int LANES    = 4;

    localparam logic [ADDR_W-1:0] ADDR_FIRST = 14'h0001;
    localparam logic [ADDR_W-1:0] ADDR_LAST  = 14'h3FFF;

    // The ring holds exactly as many words as there are usable addresses.
    localparam logic [ADDR_W-1:0] COUNT_MAX  = 14'h3FFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        EMIT  = 2'd3
    } rd_state_t;

    // Successor of an address in the ring; address zero is never produced.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr);
        return (addr == ADDR_LAST) ? ADDR_FIRST : addr + 1'b1;
    endfunction

    // Select 16-bit lane k of a RAM word, lane 0 in the low bits.
    function automatic logic [SAMPLE_W-1:0] lane_of(input logic [DATA_W-1:0] word,
                                                    input logic [1:0]        idx);
        logic [SAMPLE_W-1:0] lane;
        case (idx)
            2'd0:    lane = word[15:0];
            2'd1:    lane = word[31:16];
            2'd2:    lane = word[47:32];
            default: lane = word[63:48];
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/ram_reader_if.sv
// rtl/ram_reader_if.sv - RAM read port, writer strobe and sample stream bundle
interface ram_reader_if;
    import ram_pkg::*;

    logic                i_wr_strobe;
    logic [ADDR_W-1:0]   o_rd_addr;
    logic                o_rd_en;
    logic [DATA_W-1:0]   i_rd_data;
    logic [SAMPLE_W-1:0] o_sample;
    logic                o_sample_valid;
    logic                i_sample_ready;
    logic [ADDR_W-1:0]   o_words_avail;
    logic                o_overflow;

    // Reader side: drives the RAM read port and the sample stream.
    modport master (
        input  i_wr_strobe,
        output o_rd_addr,
        output o_rd_en,
        input  i_rd_data,
        output o_sample,
        output o_sample_valid,
        input  i_sample_ready,
        output o_words_avail,
        output o_overflow
    );

    // Environment side: writer, RAM and sample consumer.
    modport slave (
        output i_wr_strobe,
        input  o_rd_addr,
        input  o_rd_en,
        output i_rd_data,
        input  o_sample,
        input  o_sample_valid,
        output i_sample_ready,
        input  o_words_avail,
        input  o_overflow
    );

endinterface

// File: rtl/ram_addr_ptr.sv
// rtl/ram_addr_ptr.sv - wrapping ring pointer over ADDR_FIRST..ADDR_LAST
module ram_addr_ptr
    import ram_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr
);

    // Step to the next ring address on request, skipping address zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= ADDR_FIRST;
        end else if (advance) begin
            addr <= next_addr(addr);
        end
    end

endmodule

// File: rtl/ram_reader.sv
// rtl/ram_reader.sv - reads committed RAM words and streams them as 16-bit samples
module ram_reader
    import ram_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    ram_reader_if.master bus
);

    localparam logic [1:0] WAIT_LAST = 2'(RD_LATENCY - 1);

    rd_state_t           state;
    rd_state_t           state_next;
    logic [ADDR_W-1:0]   count;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [DATA_W-1:0]   hold;
    logic [1:0]          lane_idx;
    logic [1:0]          wait_cnt;
    logic                overflow;
    logic                rd_en;
    logic                capture;
    logic                emit;
    logic                accept;
    logic                count_full;
    logic                drop;

    assign accept     = emit & bus.i_sample_ready;
    assign count_full = (count == COUNT_MAX);
    // A strobe into a full ring with no read leaving it discards the oldest word.
    assign drop       = bus.i_wr_strobe & ~rd_en & count_full;

    // The pointer moves on every issued read and on every dropped word.
    ram_addr_ptr u_ptr (
        .clk     (i_clk),
        .rst     (i_rst),
        .advance (rd_en | drop),
        .addr    (rd_ptr)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-state strobes; one read outstanding at most.
    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        capture    = 1'b0;
        emit       = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                rd_en      = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    capture    = 1'b1;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                emit = 1'b1;
                if (accept && (lane_idx == 2'(LANES - 1))) begin
                    state_next = (count != '0) ? ISSUE : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Counts cycles spent waiting for the RAM; the last one is the capture cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wait_cnt <= '0;
        end else if ((state == WAIT) && !capture) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Unread-word counter; a strobe and a read in the same cycle cancel out.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count <= '0;
        end else begin
            case ({bus.i_wr_strobe, rd_en})
                2'b10: begin
                    if (!count_full) begin
                        count <= count + 1'b1;
                    end
                end
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky lap indicator, cleared only by reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

    // Holding register; data returning outside WAIT (e.g. after reset) is ignored.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold <= '0;
        end else if (capture) begin
            hold <= bus.i_rd_data;
        end
    end

    // Lane index restarts on each capture and steps on each accepted sample.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lane_idx <= '0;
        end else if (capture) begin
            lane_idx <= '0;
        end else if (accept) begin
            lane_idx <= lane_idx + 1'b1;
        end
    end

    assign bus.o_rd_addr      = rd_ptr;
    assign bus.o_rd_en        = rd_en;
    assign bus.o_sample_valid = emit;
    assign bus.o_sample       = emit ? lane_of(hold, lane_idx) : '0;
    assign bus.o_words_avail  = count;
    assign bus.o_overflow     = overflow;

endmodule

// File: tb/tb_ram_reader.sv
// tb/tb_ram_reader.sv - scoreboard and vector bench for ram_reader at latency 1 and 3
module tb_ram_reader;

    typedef struct packed {
        logic [13:0] addr;
        logic [63:0] word;
    } ent_t;

    typedef struct {
        logic        strobe;
        logic [63:0] word;
        logic        ready;
        logic        rd_en;
        logic [13:0] addr;
        logic        valid;
        logic [15:0] sample;
        logic [13:0] avail;
    } vec_t;

    localparam logic [63:0] W_A = 64'h0007_0006_0005_0004;
    localparam logic [63:0] W_B = 64'h0107_0106_0105_0104;
    localparam logic [63:0] W_C = 64'h0C03_0C02_0C01_0C00;
    localparam logic [63:0] W_D = 64'h0D03_0D02_0D01_0D00;
    localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        strobe = 1'b0;
    logic        ready = 1'b1;
    logic [63:0] wr_word = '0;
    logic [13:0] wr_ptr = 14'd1;
    logic [63:0] mem [0:16383];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    bit rec_gap = 1'b0;
    int first_rd [2];
    int first_valid [2];

    ent_t        pend_q [2][$];
    logic [15:0] emit_q [2][$];
    logic        exp_ov [2];
    logic [13:0] addr_log [$];

    logic        m_rd_en [2];
    logic [13:0] m_addr [2];
    logic        m_valid [2];
    logic [15:0] m_sample [2];
    logic [13:0] m_avail [2];
    logic        m_ov [2];

    logic        pv0 = 1'b0;
    logic [13:0] pa0 = '0;
    logic [2:0]  pv1 = '0;
    logic [13:0] pa1 [3];

    vec_t tab [21];

    ram_reader_if bus0 ();
    ram_reader_if bus1 ();

    ram_reader #(.RD_LATENCY(1)) u_dut0 (.i_clk(clk), .i_rst(rst), .bus(bus0));
    ram_reader #(.RD_LATENCY(3)) u_dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    assign bus0.i_wr_strobe    = strobe;
    assign bus1.i_wr_strobe    = strobe;
    assign bus0.i_sample_ready = ready;
    assign bus1.i_sample_ready = ready;
    assign bus0.i_rd_data      = pv0    ? mem[pa0]    : JUNK;
    assign bus1.i_rd_data      = pv1[2] ? mem[pa1[2]] : JUNK;

    assign m_rd_en[0]  = bus0.o_rd_en;
    assign m_rd_en[1]  = bus1.o_rd_en;
    assign m_addr[0]   = bus0.o_rd_addr;
    assign m_addr[1]   = bus1.o_rd_addr;
    assign m_valid[0]  = bus0.o_sample_valid;
    assign m_valid[1]  = bus1.o_sample_valid;
    assign m_sample[0] = bus0.o_sample;
    assign m_sample[1] = bus1.o_sample;
    assign m_avail[0]  = bus0.o_words_avail;
    assign m_avail[1]  = bus1.o_words_avail;
    assign m_ov[0]     = bus0.o_overflow;
    assign m_ov[1]     = bus1.o_overflow;

    // RAM with data valid only in the cycle exactly RD_LATENCY after the read.
    always @(posedge clk) begin
        pv0    <= bus0.o_rd_en;
        pa0    <= bus0.o_rd_addr;
        pv1    <= {pv1[1:0], bus1.o_rd_en};
        pa1[0] <= bus1.o_rd_addr;
        pa1[1] <= pa1[0];
        pa1[2] <= pa1[1];
    end

    function automatic vec_t mk(input logic s, input logic [63:0] w, input logic r,
                                input logic en, input logic [13:0] a, input logic v,
                                input logic [15:0] smp, input logic [13:0] av);
        vec_t t;
        t.strobe = s; t.word = w; t.ready = r; t.rd_en = en;
        t.addr = a; t.valid = v; t.sample = smp; t.avail = av;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: compare this cycle's outputs, then apply this cycle's events to the model.
    task automatic mon();
        ent_t        e;
        logic [15:0] s;
        int          c;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                pend_q[d].delete();
                emit_q[d].delete();
                exp_ov[d] = 1'b0;
                continue;
            end
            c = pend_q[d].size();
            chk($sformatf("dut%0d_avail", d), 64'(m_avail[d]), 64'(c));
            chk($sformatf("dut%0d_overflow", d), 64'(m_ov[d]), 64'(exp_ov[d]));
            if (rec_gap && m_rd_en[d] && first_rd[d] < 0) first_rd[d] = cyc;
            if (rec_gap && m_valid[d] && first_valid[d] < 0) first_valid[d] = cyc;
            if (m_valid[d] && ready) begin
                chk($sformatf("dut%0d_sample_expected", d), 64'(emit_q[d].size() != 0), 64'd1);
                if (emit_q[d].size() != 0) begin
                    s = emit_q[d].pop_front();
                    chk($sformatf("dut%0d_sample", d), 64'(m_sample[d]), 64'(s));
                end
            end
            if (m_rd_en[d]) begin
                chk($sformatf("dut%0d_rd_with_words", d), 64'(c != 0), 64'd1);
                if (d == 0) addr_log.push_back(m_addr[d]);
                if (c != 0) begin
                    e = pend_q[d].pop_front();
                    chk($sformatf("dut%0d_rd_addr", d), 64'(m_addr[d]), 64'(e.addr));
                    for (int l = 0; l < 4; l++) emit_q[d].push_back(e.word[l*16 +: 16]);
                end
            end
            if (strobe) begin
                if (!m_rd_en[d] && c == 16383) begin
                    void'(pend_q[d].pop_front());
                    exp_ov[d] = 1'b1;
                end
                pend_q[d].push_back({wr_ptr, wr_word});
            end
        end
        if (rst) begin
            wr_ptr = 14'd1;
        end else if (strobe) begin
            mem[wr_ptr] = wr_word;
            wr_ptr = (wr_ptr == 14'h3FFF) ? 14'd1 : wr_ptr + 14'd1;
        end
    endtask

    task automatic cycle_start();
        @(negedge clk);
        mon();
        cyc++;
    endtask

    task automatic cycle_end();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        cycle_start();
        cycle_end();
    endtask

    initial begin
        bit found;

        tab[0]  = mk(1'b1, W_A,   1'b1, 1'b0, 14'd1, 1'b0, 16'h0000, 14'd0);
        tab[1]  = mk(1'b0, 64'd0, 1'b1, 1'b0, 14'd1, 1'b0, 16'h0000, 14'd1);
        tab[2]  = mk(1'b0, 64'd0, 1'b1, 1'b1, 14'd1, 1'b0, 16'h0000, 14'd1);
        tab[3]  = mk(1'b0, 64'd0, 1'b1, 1'b0, 14'd2, 1'b0, 16'h0000, 14'd0);
        tab[4]  = mk(1'b0, 64'd0, 1'b1, 1'b0, 14'd2, 1'b1, 16'h0004, 14'd0);
        tab[5]  = mk(1'b0, 64'd0, 1'b1, 1'b0, 14'd2, 1'b1, 16'h0005, 14'd0);
        tab[6]  = mk(1'b0, 64'd0, 1'b1, 1'b0, 14'd2, 1'b1, 16'h0006, 14'd0);
        tab[7]  = mk(1'b0, 64'd0, 1'b1, 1'b0, 14'd2, 1'b1, 16'h0007, 14'd0);
        tab[8]  = mk(1'b0, 64'd0, 1'b1, 1'b0, 14'd2, 1'b0, 16'h0000, 14'd0);
        tab[9]  = mk(1'b1, W_B,   1'b1, 1'b0, 14'd2, 1'b0, 16'h0000, 14'd0);
        tab[10] = mk(1'b0, 64'd0, 1'b1, 1'b0, 14'd2, 1'b0, 16'h0000, 14'd1);
        tab[11] = mk(1'b0, 64'd0, 1'b1, 1'b1, 14'd2, 1'b0, 16'h0000, 14'd1);
        tab[12] = mk(1'b0, 64'd0, 1'b1, 1'b0, 14'd3, 1'b0, 16'h0000, 14'd0);
        tab[13] = mk(1'b0, 64'd0, 1'b1, 1'b0, 14'd3, 1'b1, 16'h0104, 14'd0);
        tab[14] = mk(1'b0, 64'd0, 1'b0, 1'b0, 14'd3, 1'b1, 16'h0105, 14'd0);
        tab[15] = mk(1'b0, 64'd0, 1'b0, 1'b0, 14'd3, 1'b1, 16'h0105, 14'd0);
        tab[16] = mk(1'b0, 64'd0, 1'b0, 1'b0, 14'd3, 1'b1, 16'h0105, 14'd0);
        tab[17] = mk(1'b0, 64'd0, 1'b1, 1'b0, 14'd3, 1'b1, 16'h0105, 14'd0);
        tab[18] = mk(1'b0, 64'd0, 1'b1, 1'b0, 14'd3, 1'b1, 16'h0106, 14'd0);
        tab[19] = mk(1'b0, 64'd0, 1'b1, 1'b0, 14'd3, 1'b1, 16'h0107, 14'd0);
        tab[20] = mk(1'b0, 64'd0, 1'b1, 1'b0, 14'd3, 1'b0, 16'h0000, 14'd0);
        first_rd[0] = -1; first_rd[1] = -1;
        first_valid[0] = -1; first_valid[1] = -1;

        repeat (3) cycle();
        rst = 1'b0;

        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d_reset_addr", d), 64'(m_addr[d]), 64'h1);
            chk($sformatf("dut%0d_reset_rd_en", d), 64'(m_rd_en[d]), 64'h0);
            chk($sformatf("dut%0d_reset_valid", d), 64'(m_valid[d]), 64'h0);
            chk($sformatf("dut%0d_reset_sample", d), 64'(m_sample[d]), 64'h0);
            chk($sformatf("dut%0d_reset_overflow", d), 64'(m_ov[d]), 64'h0);
        end

        // Single words at latency 1 against the cycle table; latency 3 via scoreboard.
        rec_gap = 1'b1;
        for (int i = 0; i < 21; i++) begin
            strobe = tab[i].strobe;
            wr_word = tab[i].word;
            ready = tab[i].ready;
            cycle_start();
            chk($sformatf("tab%0d_rd_en", i), 64'(m_rd_en[0]), 64'(tab[i].rd_en));
            chk($sformatf("tab%0d_rd_addr", i), 64'(m_addr[0]), 64'(tab[i].addr));
            chk($sformatf("tab%0d_valid", i), 64'(m_valid[0]), 64'(tab[i].valid));
            chk($sformatf("tab%0d_sample", i), 64'(m_sample[0]), 64'(tab[i].sample));
            chk($sformatf("tab%0d_avail", i), 64'(m_avail[0]), 64'(tab[i].avail));
            cycle_end();
        end
        rec_gap = 1'b0;
        strobe = 1'b0;
        ready = 1'b1;
        chk("dut0_capture_gap", 64'(first_valid[0] - first_rd[0]), 64'd2);
        chk("dut1_capture_gap", 64'(first_valid[1] - first_rd[1]), 64'd4);

        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (pend_q[1].size() == 0 && emit_q[1].size() == 0 && !m_valid[1]) begin
                found = 1'b1;
                break;
            end
            cycle();
        end
        chk("drain_timeout", 64'(found), 64'd1);

        // Strobe in the same cycle as a read at count 1, then reset during lane 2.
        strobe = 1'b1; wr_word = W_C;
        cycle();
        strobe = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (m_rd_en[0]) begin
                found = 1'b1;
                break;
            end
            cycle();
        end
        chk("issue_timeout", 64'(found), 64'd1);
        strobe = 1'b1; wr_word = W_D;
        cycle();
        strobe = 1'b0;
        chk("coincident_avail", 64'(m_avail[0]), 64'd1);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (m_valid[0] && emit_q[0].size() == 2) begin
                found = 1'b1;
                break;
            end
            cycle();
        end
        chk("lane2_timeout", 64'(found), 64'd1);
        chk("pre_reset_lane2", 64'(m_sample[0]), 64'h0C02);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mid_emit_rst_valid", 64'(m_valid[0]), 64'h0);
        chk("mid_emit_rst_avail", 64'(m_avail[0]), 64'h0);
        chk("mid_emit_rst_addr", 64'(m_addr[0]), 64'h1);
        chk("mid_wait_rst_valid", 64'(m_valid[1]), 64'h0);

        // Reset wins over a strobe in the same cycle.
        rst = 1'b1; strobe = 1'b1; wr_word = W_A;
        cycle();
        rst = 1'b0; strobe = 1'b0;
        chk("rst_strobe_dut0_avail", 64'(m_avail[0]), 64'h0);
        chk("rst_strobe_dut1_avail", 64'(m_avail[1]), 64'h0);
        repeat (3) cycle();

        // Flood with the consumer stalled until the pointer is pushed to 0x3FFF.
        ready = 1'b0;
        for (int k = 1; k <= 32765; k++) begin
            strobe = 1'b1;
            wr_word = {$urandom, $urandom};
            cycle();
            if (k == 16384) begin
                chk("full_avail", 64'(m_avail[0]), 64'd16383);
                chk("full_no_overflow", 64'(m_ov[0]), 64'd0);
            end
            if (k == 16385) begin
                chk("lap_avail", 64'(m_avail[0]), 64'd16383);
                chk("lap_overflow", 64'(m_ov[0]), 64'd1);
                chk("lap_dut1_overflow", 64'(m_ov[1]), 64'd1);
            end
        end
        strobe = 1'b0;
        chk("flood_ptr", 64'(m_addr[0]), 64'h3FFF);
        addr_log.delete();
        ready = 1'b1;
        repeat (45) cycle();
        chk("wrap_reads", 64'(addr_log.size() >= 2), 64'd1);
        if (addr_log.size() >= 2) begin
            chk("wrap_first_addr", 64'(addr_log[0]), 64'h3FFF);
            chk("wrap_second_addr", 64'(addr_log[1]), 64'h0001);
        end
        chk("overflow_sticky", 64'(m_ov[0]), 64'd1);

        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("final_overflow_cleared", 64'(m_ov[0]), 64'd0);
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
